// File: rtl/display_scheduler_if.sv
// Display ownership bundle: two requesters in, grants, digits and blank out.
// master = application side, slave = scheduler side.
interface display_scheduler_if;
  logic        req_a;
  logic [15:0] value_a;
  logic        req_b;
  logic [15:0] value_b;
  logic        grant_a;
  logic        grant_b;
  logic [3:0]  number3;
  logic [3:0]  number2;
  logic [3:0]  number1;
  logic [3:0]  number0;
  logic        blank;

  modport master (
    output req_a, value_a, req_b, value_b,
    input  grant_a, grant_b,
    input  number3, number2, number1, number0,
    input  blank
  );

  modport slave (
    input  req_a, value_a, req_b, value_b,
    output grant_a, grant_b,
    output number3, number2, number1, number0,
    output blank
  );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin display arbiter with minimum dwell under contention.
// Ports: clock, reset_n (async low), bus (slave: reqs/values in, grants/digits/blank out).
module display_scheduler #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int CNT_W        = 26
) (
  input logic                clock,
  input logic                reset_n,
  display_scheduler_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHOW_A = 2'd1;
  localparam logic [1:0] SHOW_B = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // 1 = B was served last
  logic             last_b_q, last_b_d;
  logic [15:0]      num_q, num_d;
  logic             grant_a_q, grant_a_d;
  logic             grant_b_q, grant_b_d;
  logic             blank_q, blank_d;

  logic dwell_done;
  logic to_a;
  logic to_b;

  assign dwell_done = (cnt_q == CNT_LAST);

  always_comb begin
    to_a = 1'b0;
    to_b = 1'b0;
    state_d = state_q;
    cnt_d = cnt_q;
    last_b_d = last_b_q;
    num_d = num_q;
    case (state_q)
      IDLE: begin
        if (bus.req_a && (!bus.req_b || last_b_q)) to_a = 1'b1;
        else if (bus.req_b)                        to_b = 1'b1;
      end
      SHOW_A: begin
        if (!bus.req_a && bus.req_b) to_b = 1'b1;
        else if (!bus.req_a) begin
          state_d = IDLE;
          num_d = '0;
        end else if (bus.req_b && dwell_done) to_b = 1'b1;
        else begin
          num_d = bus.value_a;
          if (!dwell_done) cnt_d = cnt_q + 1'b1;
        end
      end
      SHOW_B: begin
        if (!bus.req_b && bus.req_a) to_a = 1'b1;
        else if (!bus.req_b) begin
          state_d = IDLE;
          num_d = '0;
        end else if (bus.req_a && dwell_done) to_a = 1'b1;
        else begin
          num_d = bus.value_b;
          if (!dwell_done) cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        num_d = '0;
      end
    endcase
    if (to_a) begin
      state_d = SHOW_A;
      cnt_d = '0;
      last_b_d = 1'b0;
      num_d = bus.value_a;
    end
    if (to_b) begin
      state_d = SHOW_B;
      cnt_d = '0;
      last_b_d = 1'b1;
      num_d = bus.value_b;
    end
    grant_a_d = (state_d == SHOW_A);
    grant_b_d = (state_d == SHOW_B);
    blank_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_b_q <= 1'b1;
      num_q <= '0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_b_q <= last_b_d;
      num_q <= num_d;
      grant_a_q <= grant_a_d;
      grant_b_q <= grant_b_d;
      blank_q <= blank_d;
    end
  end

  assign bus.grant_a = grant_a_q;
  assign bus.grant_b = grant_b_q;
  assign bus.number3 = num_q[15:12];
  assign bus.number2 = num_q[11:8];
  assign bus.number1 = num_q[7:4];
  assign bus.number0 = num_q[3:0];
  assign bus.blank = blank_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: DWELL 4 and DWELL 1 instances
// checked against an ownership/time-held reference model.
module tb_display_scheduler;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  display_scheduler_if if4 ();
  display_scheduler_if if1 ();

  display_scheduler #(.DWELL_CYCLES(4), .CNT_W(3)) dut4 (
    .clock(clock), .reset_n(reset_n), .bus(if4.slave));
  display_scheduler #(.DWELL_CYCLES(1), .CNT_W(2)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(if1.slave));

  // owner: 0 none, 1 A, 2 B; held: cycles shown incl. current; last: 1 A, 2 B
  typedef struct packed {
    int owner;
    int held;
    int last;
  } mstate_t;

  localparam mstate_t M_RST = '{owner: 0, held: 0, last: 2};

  function automatic mstate_t mnext(mstate_t s, logic ra, logic rb, int d);
    mstate_t n;
    logic own;
    logic oth;
    n = s;
    if (s.owner == 0) begin
      if (ra && rb) n.owner = (s.last == 1) ? 2 : 1;
      else if (ra)  n.owner = 1;
      else if (rb)  n.owner = 2;
    end else begin
      own = (s.owner == 1) ? ra : rb;
      oth = (s.owner == 1) ? rb : ra;
      if (!own) n.owner = oth ? 3 - s.owner : 0;
      else if (oth && s.held >= d) n.owner = 3 - s.owner;
    end
    if (n.owner == 0) n.held = 0;
    else if (n.owner != s.owner) begin
      n.held = 1;
      n.last = n.owner;
    end else n.held = s.held + 1;
    return n;
  endfunction

  mstate_t m4, m1;
  logic [15:0] ev4, ev1;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m4 = M_RST; m1 = M_RST; ev4 = '0; ev1 = '0;
    end else begin
      m4 = mnext(m4, if4.req_a, if4.req_b, 4);
      m1 = mnext(m1, if1.req_a, if1.req_b, 1);
      ev4 = (m4.owner == 1) ? if4.value_a : (m4.owner == 2) ? if4.value_b : 16'h0;
      ev1 = (m1.owner == 1) ? if1.value_a : (m1.owner == 2) ? if1.value_b : 16'h0;
    end
  end

  wire [15:0] n4 = {if4.number3, if4.number2, if4.number1, if4.number0};
  wire [15:0] n1 = {if1.number3, if1.number2, if1.number1, if1.number0};
  wire [3:0] o4 = {if4.grant_a, if4.grant_b, if4.blank, 1'b0};
  wire [3:0] o1 = {if1.grant_a, if1.grant_b, if1.blank, 1'b0};

  function automatic logic [3:0] mexp(mstate_t s);
    return {s.owner == 1, s.owner == 2, s.owner == 0, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bit seen;
    @(negedge clock);
    reset_n = 1'b0;
    if4.req_a = 1; if4.req_b = 1; if4.value_a = 16'hA1A1; if4.value_b = 16'hB2B2;
    tick(); tick();
    checks++;
    if (o4 !== 4'b0010 || n4 !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got g/b/bl=%b num=%h want 0010 0000", o4, n4);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    checks++;
    if (if4.grant_a !== 1'b1 || if4.grant_b !== 1'b0 || n4 !== 16'hA1A1) begin
      failures++;
      $display("FAIL reset_first_grant got ga=%b gb=%b num=%h want 1 0 a1a1",
               if4.grant_a, if4.grant_b, n4);
    end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (if4.grant_b === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_wait_grant_b timed out got gb=%b want 1", if4.grant_b);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (if4.grant_b !== 1'b0 || if4.blank !== 1'b1 || n4 !== 16'h0) begin
      failures++;
      $display("FAIL reset_async got gb=%b blank=%b num=%h want 0 1 0000",
               if4.grant_b, if4.blank, n4);
    end
    if4.req_a = 0; if4.req_b = 0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    @(negedge clock);
    if4.req_a = 1; if4.value_a = 16'h1234;
    tick();
    checks++;
    if (if4.grant_a !== 1'b1 || n4 !== 16'h1234 || if4.blank !== 1'b0) begin
      failures++;
      $display("FAIL single_grant got ga=%b num=%h blank=%b want 1 1234 0",
               if4.grant_a, n4, if4.blank);
    end
    @(negedge clock);
    if4.value_a = 16'hBEEF;
    tick();
    checks++;
    if (if4.number3 !== 4'hB || if4.number2 !== 4'hE ||
        if4.number1 !== 4'hE || if4.number0 !== 4'hF) begin
      failures++;
      $display("FAIL single_live_update got num=%h want beef", n4);
    end
    @(negedge clock);
    if4.req_a = 0;
    tick();
    checks++;
    if (if4.grant_a !== 1'b0 || n4 !== 16'h0 || if4.blank !== 1'b1) begin
      failures++;
      $display("FAIL single_release got ga=%b num=%h blank=%b want 0 0000 1",
               if4.grant_a, n4, if4.blank);
    end
  endtask

  task automatic test_contention();
    bit first_a;
    @(negedge clock);
    if4.req_a = 1; if4.req_b = 1;
    for (int i = 0; i < 24; i++) begin
      if4.value_a = 16'($urandom); if4.value_b = 16'($urandom);
      tick();
      if (i == 0) first_a = if4.grant_a;
      checks++;
      if (if4.grant_a !== (((i / 4) % 2 == 0) ~^ first_a) ||
          (if4.grant_a & if4.grant_b) !== 1'b0 || if4.blank !== 1'b0) begin
        failures++;
        $display("FAIL contention_pattern cyc=%0d got ga=%b gb=%b bl=%b", i,
                 if4.grant_a, if4.grant_b, if4.blank);
      end
      checks++;
      if (o4 !== mexp(m4) || n4 !== ev4) begin
        failures++;
        $display("FAIL contention_model cyc=%0d got %b/%h want %b/%h", i, o4, n4,
                 mexp(m4), ev4);
      end
      @(negedge clock);
    end
    if4.req_a = 0; if4.req_b = 0;
    tick();
  endtask

  task automatic test_early_release();
    @(negedge clock);
    if4.req_a = 1; if4.value_a = 16'h0A0A; if4.value_b = 16'h5B5B;
    tick();
    @(negedge clock);
    if4.req_b = 1;
    tick();
    @(negedge clock);
    if4.req_a = 0;
    tick();
    checks++;
    if (if4.grant_b !== 1'b1 || if4.grant_a !== 1'b0 || n4 !== 16'h5B5B) begin
      failures++;
      $display("FAIL early_release got ga=%b gb=%b num=%h want 0 1 5b5b",
               if4.grant_a, if4.grant_b, n4);
    end
    @(negedge clock);
    if4.req_b = 0;
    tick();
  endtask

  task automatic test_fairness();
    @(negedge clock);
    if4.req_b = 1;
    repeat (3) tick();
    @(negedge clock);
    if4.req_b = 0;
    tick();
    @(negedge clock);
    if4.req_a = 1; if4.req_b = 1;
    tick();
    checks++;
    if (if4.grant_a !== 1'b1 || if4.grant_b !== 1'b0) begin
      failures++;
      $display("FAIL fairness got ga=%b gb=%b want 1 0", if4.grant_a, if4.grant_b);
    end
    @(negedge clock);
    if4.req_a = 0; if4.req_b = 0;
    tick();
  endtask

  task automatic test_saturation();
    logic prev_a;
    @(negedge clock);
    if1.req_a = 1; if1.req_b = 1;
    tick();
    prev_a = if1.grant_a;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (if1.grant_a !== ~prev_a || if1.grant_b !== prev_a || o1 !== mexp(m1)) begin
        failures++;
        $display("FAIL dwell1_alternate cyc=%0d got ga=%b gb=%b prev_a=%b",
                 i, if1.grant_a, if1.grant_b, prev_a);
      end
      prev_a = if1.grant_a;
    end
    @(negedge clock);
    if1.req_a = 0; if1.req_b = 0;
    if4.req_a = 1;
    for (int i = 0; i < 100; i++) tick();
    checks++;
    if (if4.grant_a !== 1'b1) begin
      failures++;
      $display("FAIL saturation_hold got ga=%b want 1", if4.grant_a);
    end
    @(negedge clock);
    if4.req_b = 1;
    tick();
    checks++;
    if (if4.grant_b !== 1'b1 || if4.grant_a !== 1'b0) begin
      failures++;
      $display("FAIL saturation_switch got ga=%b gb=%b want 0 1",
               if4.grant_a, if4.grant_b);
    end
    @(negedge clock);
    if4.req_a = 0; if4.req_b = 0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if4.req_a = ($urandom_range(0, 9) < 7); if4.req_b = ($urandom_range(0, 9) < 6);
      if1.req_a = ($urandom_range(0, 9) < 7); if1.req_b = ($urandom_range(0, 9) < 6);
      if4.value_a = 16'($urandom); if4.value_b = 16'($urandom);
      if1.value_a = 16'($urandom); if1.value_b = 16'($urandom);
      tick();
      checks++;
      if (o4 !== mexp(m4) || n4 !== ev4) begin
        failures++;
        $display("FAIL random_d4 cyc=%0d got %b/%h want %b/%h", i, o4, n4, mexp(m4), ev4);
      end
      checks++;
      if (o1 !== mexp(m1) || n1 !== ev1) begin
        failures++;
        $display("FAIL random_d1 cyc=%0d got %b/%h want %b/%h", i, o1, n1, mexp(m1), ev1);
      end
    end
    @(negedge clock);
    if4.req_a = 0; if4.req_b = 0; if1.req_a = 0; if1.req_b = 0;
    tick();
  endtask

  initial begin
    if4.req_a = 0; if4.req_b = 0; if4.value_a = '0; if4.value_b = '0;
    if1.req_a = 0; if1.req_b = 0; if1.value_a = '0; if1.value_b = '0;
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_fairness();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
